mem_align_unit: RTL and testbench
=================================

# mem_align_unit

Multicycle load/store unit between the RV32I control FSM and the word-addressed memory port. The control FSM pulses `start` in its memory state; this unit latches address, data and funct3. It then drives a word-aligned read or write with byte enables and holds it until `mem_resp`. It returns sign-/zero-extended load data with a one-cycle `done` pulse, which the control FSM uses to leave its memory state.

## Interface
- `TIMEOUT_CYCLES`, 1023: maximum REQ-state cycles before aborting with `err`; 0 disables the watchdog.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse, sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: load_funct3_t / store_funct3_t encoding.
- `addr` in 32: byte address (ALU output).
- `store_data` in 32: rs2 value, unshifted.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; indicates illegal funct3, timeout, or misalignment (misalignment only with the macro).
- `load_data` out 32: extended load result; holds until the next `done`.
- `rmask` out 4, `wmask` out 4: RVFI masks for the completed access; valid with `done`.
- `mem_address` out 32: `{addr_q[31:2], 2'b00}`.
- `mem_read` out 1, `mem_write` out 1: access strobes.
- `mem_byte_enable` out 4: byte lanes for the access.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rdata` in 32: read data from memory.
- `mem_resp` in 1: memory response; completes the access.

## Operation
- States: IDLE, REQ, RESP.
- IDLE, `start`=1:
  - Latch `addr`, `store_data`, `funct3` and `is_store`, then go to REQ.
  - If funct3 is illegal (load 3/6/7, store ≥3), skip the access and go to RESP with `err`=1.
- IDLE, `start` while busy: `start` in any other state is ignored.
- REQ: assert `mem_read` or `mem_write` (never both) with stable address, enables and data.
  - `mem_resp`=1 → RESP. Capture `mem_rdata` on loads.
  - Watchdog count reaches `TIMEOUT_CYCLES` → RESP with `err`=1 and strobes dropped.
- RESP: `done`=1 for one cycle, then IDLE.
- Offset `o` = `addr_q[1:0]`.
  - Byte access: enable `4'b0001<<o`.
  - Half access: enable `4'b0011<<{o[1],1'b0}`.
  - Word access: enable `4'b1111`.
- `mem_wdata` = `store_data << (8*lane_offset)`, where lane_offset is `o`, `{o[1],0}` or 0 for byte, half and word.
- Load extraction selects the addressed lane(s):
  - lb/lh sign-extend to 32 bits.
  - lbu/lhu zero-extend to 32 bits.
  - lw passes the word through unchanged.
- `rmask` = enable for loads, else 0. `wmask` = enable for stores, else 0. Both are 0 on an error completion.
- A `mem_resp` seen in IDLE or RESP is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_read`, `mem_write` = 0; `load_data`, `rmask`, `wmask`, `mem_address`, `mem_byte_enable`, `mem_wdata` = 0.
- `start` at cycle 0 → strobe from cycle 1. If `mem_resp` arrives in REQ cycle N (N≥1), `done` is asserted at cycle N+1.
- Minimum latency: 2 cycles from `start` to `done`, when `mem_resp` arrives in the first REQ cycle.
- Illegal funct3 or misaligned access: `done` at cycle 1, with no strobe.
- `rst` asserted mid-transaction: strobes drop immediately and the access is abandoned. The watchdog counter clears.
- All outputs are registered. No combinational path from `mem_resp` to `done`.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Half access with `o[0]`=1, or word access with `o`≠0, goes IDLE → RESP with `err`=1.
  - No memory strobe is issued and `load_data` is unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - Misaligned low bits are silently dropped; the access proceeds at the aligned lane.
  - `err` then covers only illegal funct3 and timeout.

## Structure
- Shared package `rv32i_types` holds:
  - `mau_state_t` (IDLE/REQ/RESP);
  - the lane-offset helper constants;
  - the existing load/store funct3 typedefs.
- One combinational sub-module, `load_extract` (inputs `mem_rdata`, funct3, offset; output the extended word), instantiated once.
- Everything else lives in `mem_align_unit`.

## Test plan
- lw at 0x100, memory returns 0xDEADBEEF after 3 REQ cycles → `mem_address`=0x100, enable 1111, `done` at cycle 4, `load_data`=0xDEADBEEF, `rmask`=1111.
- lb at 0x103 with word 0x80FF0000 → enable 1000, `load_data`=0xFFFFFF80. lbu at the same address → 0x00000080.
- sh at 0x202, `store_data`=0x1234ABCD → `mem_address`=0x200, enable 1100, `mem_wdata`=0xABCD0000, `wmask`=1100, `mem_read`=0.
- lw at 0x101:
  - With the macro: `done`+`err` at cycle 1, no strobe.
  - Without the macro: reads 0x100 with enable 1111.
- `TIMEOUT_CYCLES`=4, `mem_resp` held low → strobe for 4 cycles, then `done`+`err`, `rmask`=0. A late `mem_resp` afterwards has no effect.
- `rst` low during REQ, then `start` while busy → strobes 0 immediately. After release, a new sb at 0x3 issues enable 1000. A second `start` during REQ is ignored.

Source files
------------

// File: rtl/mem_align_unit_pkg.sv
// rtl/mem_align_unit_pkg.sv - shared RV32I types and lane helpers for the load/store unit
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mau_state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    // Access size is funct3[1:0] for both loads and stores
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Byte lane the access starts at once the low address bits are forced to its natural alignment
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] o);
        case (size)
            SIZE_BYTE: lane_offset = o;
            SIZE_HALF: lane_offset = {o[1], 1'b0};
            default:   lane_offset = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] o);
        case (size)
            SIZE_BYTE: lane_enable = 4'b0001 << o;
            SIZE_HALF: lane_enable = 4'b0011 << {o[1], 1'b0};
            default:   lane_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            funct3_legal = (f3 == SB) || (f3 == SH) || (f3 == SW);
        else
            funct3_legal = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] o);
        case (size)
            SIZE_HALF: misaligned = o[0];
            SIZE_WORD: misaligned = (o != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit_load_extract.sv
// rtl/mem_align_unit_load_extract.sv - selects the addressed lane(s) of a read word and extends them
module load_extract
    import rv32i_types::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Shift the addressed lane down to bit 0, then extend according to funct3
    always_comb begin
        shifted = mem_rdata_i >> {lane_offset(funct3_i[1:0], offset_i), 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        case (funct3_i)
            LB:      data_o = {{24{lane_b[7]}}, lane_b};
            LH:      data_o = {{16{lane_h[15]}}, lane_h};
            LBU:     data_o = {24'h000000, lane_b};
            LHU:     data_o = {16'h0000, lane_h};
            default: data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - multicycle RV32I load/store unit; MISALIGN_TRAP_EN enables misalignment traps
module mem_align_unit
    import rv32i_types::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    // Watchdog counts REQ cycles 0..TIMEOUT_CYCLES-1 and fires on the last one
    localparam int WDOG_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    mau_state_t        state_q;
    logic [1:0]        offset_q;
    logic [2:0]        funct3_q;
    logic              is_store_q;
    logic [WDOG_W-1:0] wdog_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       load_data_q;
    logic [3:0]        rmask_q;
    logic [3:0]        wmask_q;
    logic [31:0]       mem_address_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;

    logic [1:0]        start_size;
    logic [3:0]        start_be;
    logic [31:0]       start_wdata;
    logic              start_legal;
    logic              start_trap;
    logic [31:0]       load_data_d;

    // Decode the request presented with start so it can be latched in one edge
    always_comb begin
        start_size  = funct3[1:0];
        start_be    = lane_enable(start_size, addr[1:0]);
        start_wdata = store_data << {lane_offset(start_size, addr[1:0]), 3'b000};
        start_legal = funct3_legal(is_store, funct3);
`ifdef MISALIGN_TRAP_EN
        start_trap  = misaligned(start_size, addr[1:0]);
`else
        start_trap  = 1'b0;
`endif
    end

    load_extract u_load_extract (
        .mem_rdata_i (mem_rdata),
        .funct3_i    (funct3_q),
        .offset_i    (offset_q),
        .data_o      (load_data_d)
    );

    // Control FSM; every output is a register updated on state transitions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            offset_q      <= 2'b00;
            funct3_q      <= 3'b000;
            is_store_q    <= 1'b0;
            wdog_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            load_data_q   <= 32'h0;
            rmask_q       <= 4'h0;
            wmask_q       <= 4'h0;
            mem_address_q <= 32'h0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            be_q          <= 4'h0;
            wdata_q       <= 32'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        offset_q      <= addr[1:0];
                        funct3_q      <= funct3;
                        is_store_q    <= is_store;
                        mem_address_q <= {addr[31:2], 2'b00};
                        be_q          <= start_be;
                        wdata_q       <= start_wdata;
                        wdog_q        <= '0;
                        busy_q        <= 1'b1;
                        if (!start_legal || start_trap) begin
                            // Rejected before any memory traffic; report straight away
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rmask_q <= 4'h0;
                            wmask_q <= 4'h0;
                        end else begin
                            state_q     <= REQ;
                            mem_read_q  <= !is_store;
                            mem_write_q <= is_store;
                        end
                    end
                end
                REQ: begin
                    if (mem_resp) begin
                        state_q     <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b0;
                        rmask_q     <= is_store_q ? 4'h0 : be_q;
                        wmask_q     <= is_store_q ? be_q : 4'h0;
                        if (!is_store_q)
                            load_data_q <= load_data_d;
                    end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
                        state_q     <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        rmask_q     <= 4'h0;
                        wmask_q     <= 4'h0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    wdog_q  <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign load_data       = load_data_q;
    assign rmask           = rmask_q;
    assign wmask           = wmask_q;
    assign mem_address     = mem_address_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - scoreboard bench for mem_align_unit with a byte-arithmetic reference model
module tb_mem_align_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_resp = 1'b0;
    logic        busy, done, err, mem_read, mem_write;
    logic [31:0] load_data, mem_address, mem_wdata;
    logic [3:0]  rmask, wmask, mem_byte_enable;

    mem_align_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .is_store        (is_store),
        .funct3          (funct3),
        .addr            (addr),
        .store_data      (store_data),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .load_data       (load_data),
        .rmask           (rmask),
        .wmask           (wmask),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          wr;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        logic [3:0]  rm;
        logic [3:0]  wm;
        int          cyc;
        int          strobes;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    bit prev_stb = 1'b0;
    logic [31:0] model_ld = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event seen/missing, expected otherwise", name);
    endtask

    // Monitor: checks each new memory request and each done pulse against the queues
    always @(negedge clk) begin
        req_t  r;
        resp_t e;
        bit    stb;
        if (!rst) begin
            strobe_cnt = 0;
            prev_stb   = 1'b0;
        end else begin
            stb = mem_read | mem_write;
            if (stb) begin
                if (!prev_stb) begin
                    if (req_q.size() == 0) begin
                        fail_evt("unexpected_strobe");
                    end else begin
                        r = req_q.pop_front();
                        chk("mem_address", mem_address, r.addr);
                        chk("mem_byte_enable", {28'h0, mem_byte_enable}, {28'h0, r.be});
                        chk("rd_wr_strobes", {30'h0, mem_read, mem_write}, {30'h0, !r.wr, r.wr});
                        if (r.wr) chk("mem_wdata", mem_wdata, r.wdata);
                    end
                end
                strobe_cnt++;
            end
            prev_stb = stb;
            if (done) begin
                done_cnt++;
                if (resp_q.size() == 0) begin
                    fail_evt("unexpected_done");
                end else begin
                    e = resp_q.pop_front();
                    chk("err", {31'h0, err}, {31'h0, e.err});
                    chk("load_data", load_data, e.ld);
                    chk("rmask", {28'h0, rmask}, {28'h0, e.rm});
                    chk("wmask", {28'h0, wmask}, {28'h0, e.wm});
                    chk("done_cycle", cyc, e.cyc);
                    chk("strobe_cycles", strobe_cnt, e.strobes);
                end
                strobe_cnt = 0;
            end
        end
    end

    // One transaction: n = REQ cycle carrying mem_resp (0 = never), extra = cycle of an ignored start
    task automatic txn(input bit st, input bit [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int n, input int extra);
        int          sz, off, lat, nstb, d0;
        bit          legal, mis, acc, got;
        logic [31:0] lanemask, wd, ld;
        logic [3:0]  be;
        req_t        r;
        resp_t       e;

        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis   = (a % sz) != 0;
`endif
        acc   = legal && !mis;
        off   = (sz == 1) ? int'(a % 4) : (sz == 2) ? int'((a % 4) / 2 * 2) : 0;
        lanemask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        be    = 4'(((1 << sz) - 1) << off);
        wd    = sd << (8 * off);
        ld    = (rd >> (8 * off)) & lanemask;
        if (!f3[2] && sz < 4 && ld[8 * sz - 1]) ld = ld | ~lanemask;

        if (acc && n != 0) begin
            e.err = 1'b0;
            e.rm  = st ? 4'h0 : be;
            e.wm  = st ? be : 4'h0;
            if (!st) model_ld = ld;
            lat   = n + 1;
            nstb  = n;
        end else if (acc) begin
            e.err = 1'b1; e.rm = 4'h0; e.wm = 4'h0;
            lat   = TO + 1;
            nstb  = TO;
        end else begin
            e.err = 1'b1; e.rm = 4'h0; e.wm = 4'h0;
            lat   = 1;
            nstb  = 0;
        end
        e.ld      = model_ld;
        e.strobes = nstb;

        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd;
        e.cyc = cyc + lat;
        if (acc) begin
            r.addr = a & 32'hFFFF_FFFC; r.be = be; r.wdata = wd; r.wr = st;
            req_q.push_back(r);
        end
        resp_q.push_back(e);
        d0  = done_cnt;
        got = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == extra);
            if (k == extra) begin
                is_store = ~st; funct3 = 3'b010; addr = 32'h0000_0FFC;
            end
            mem_resp = acc && (n != 0) && (k == n);
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        mem_resp = 1'b0;
        if (!got) fail_evt("done_timeout");
    endtask

    initial begin
        req_t r;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_masks", {24'h0, rmask, wmask}, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_be", {28'h0, mem_byte_enable}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 0);
        txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 0);
        txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 0);
        txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 2, 0);
        txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 1, 0);
        txn(1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'h8001_7FFF, 2, 0);
        txn(1'b0, 3'b101, 32'h0000_0106, 32'h0, 32'h8001_7FFF, 1, 0);
        txn(1'b0, 3'b011, 32'h0000_0108, 32'h0, 32'h5555_5555, 1, 0);
        txn(1'b1, 3'b100, 32'h0000_0108, 32'hFFFF_FFFF, 32'h0, 1, 0);
        txn(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, TO, 0);
        txn(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h7777_7777, 0, 0);

        // A late response in IDLE must not produce anything
        @(negedge clk); mem_resp = 1'b1;
        @(negedge clk); mem_resp = 1'b0;
        @(negedge clk);
        chk("late_resp_busy", {31'h0, busy}, 32'h0);

        // Abandon a load mid-REQ with reset, start while held, then a fresh store
        r.addr = 32'h0000_0100; r.be = 4'hF; r.wdata = 32'h0; r.wr = 1'b0;
        req_q.push_back(r);
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_read", {31'h0, mem_read}, 32'h0);
        chk("midrst_write", {31'h0, mem_write}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        req_q.delete();
        resp_q.delete();
        model_ld = 32'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; rst = 1'b1;
        txn(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0, 3, 2);

        for (int i = 0; i < 150; i++) begin
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(0, TO), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        repeat (3) @(negedge clk);
        if (req_q.size() != 0 || resp_q.size() != 0) fail_evt("queues_not_drained");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
